// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared FSM encoding, default geometry and instruction width for the loader.
package imem_loader_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CSUM = 2'd2, DONE = 2'd3} state_e;
  localparam int DEPTH_DEF = 256;
  localparam int ADDR_W_DEF = 8;
  localparam int INSTR_W = 32;
endpackage

// File: rtl/imem_ram.sv
// imem_ram: DEPTH x W instruction RAM, one synchronous write port and one asynchronous read port.
module imem_ram #(
  parameter int DEPTH = 256,
  parameter int ADDR_W = 8,
  parameter int W = 32
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [W-1:0]      wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [W-1:0]      rdata_o
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk_i) if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/imem_loader.sv
// imem_loader: assembles a big-endian byte stream into instruction words and holds the core until loaded.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before releasing the core.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W:0]    len,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  fetch_addr,
  output logic [INSTR_W-1:0] fetch_instr,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               cpu_hold
);
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e END_S = CSUM;
  logic [7:0] csum_q;
  logic       err_q;
  assign err = err_q;
`else
  localparam state_e END_S = DONE;
  assign err = 1'b0;
`endif
  state_e             state_q;
  logic               in_ready_q, busy_q, done_q, cpu_hold_q;
  logic [1:0]         bcnt_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W:0]    rem_q, len_d;
  logic [23:0]        word_q;
  logic [INSTR_W-1:0] word_d;
  logic               xfer_d, we_d, start_d, to_end_d;
  assign len_d    = (len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : len;
  assign word_d   = {word_q, in_data};
  assign xfer_d   = in_valid && in_ready_q;
  assign start_d  = start && (state_q == IDLE || state_q == DONE);
  assign we_d     = xfer_d && state_q == LOAD && bcnt_q == 2'd3;
  assign to_end_d = (start_d && len_d == '0) || (we_d && rem_q == (ADDR_W+1)'(1));
  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign cpu_hold = cpu_hold_q;
  // later assignments in this block take priority, so the end-state transition overrides the LOAD entry
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cpu_hold_q <= 1'b1;
      bcnt_q     <= '0;
      addr_q     <= '0;
      rem_q      <= '0;
      word_q     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      if (start_d) begin
        state_q    <= LOAD;
        in_ready_q <= 1'b1;
        busy_q     <= 1'b1;
        done_q     <= 1'b0;
        cpu_hold_q <= 1'b1;
        bcnt_q     <= '0;
        addr_q     <= '0;
        rem_q      <= len_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_q     <= '0;
        err_q      <= 1'b0;
`endif
      end
      if (xfer_d && state_q == LOAD) begin
        bcnt_q <= bcnt_q + 2'd1;
        word_q <= word_d[23:0];
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_q <= csum_q ^ in_data;
`endif
      end
      if (we_d) begin
        addr_q <= addr_q + 1'b1;
        rem_q  <= rem_q - 1'b1;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (xfer_d && state_q == CSUM) begin
        state_q    <= DONE;
        in_ready_q <= 1'b0;
        busy_q     <= 1'b0;
        done_q     <= 1'b1;
        cpu_hold_q <= in_data != csum_q;
        err_q      <= in_data != csum_q;
      end
`endif
      if (to_end_d) begin
        state_q    <= END_S;
        in_ready_q <= END_S == CSUM;
        busy_q     <= END_S == CSUM;
        done_q     <= END_S == DONE;
        cpu_hold_q <= END_S != DONE;
      end
    end
  end
  imem_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .W(INSTR_W)) u_ram (
    .clk_i  (clk),
    .we_i   (we_d),
    .waddr_i(addr_q),
    .wdata_i(word_d),
    .raddr_i(fetch_addr),
    .rdata_o(fetch_instr)
  );
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed loads checked every cycle against a byte-level model plus literal expectations.
module tb_imem_loader;
  logic        clk = 0, reset = 1, start = 0, in_valid = 0;
  logic [8:0]  len = '0;
  logic [7:0]  in_data = '0, fetch_addr = '0;
  logic        in_ready, busy, done, err, cpu_hold;
  logic [31:0] fetch_instr;
  int passed = 0, total = 0;
  logic [31:0] exp_mem [256];
  bit          known [256];
  bit          m_init, m_active, m_csw, m_done, m_err;
  int          m_words, m_bytes, m_addr;
  logic [7:0]  m_xor;
  logic [31:0] m_word;
  logic [7:0]  img [8] = '{8'hE2, 8'h11, 8'h00, 8'h00, 8'hE0, 8'h80, 8'h51, 8'h83};

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .fetch_addr(fetch_addr), .fetch_instr(fetch_instr), .busy(busy),
    .done(done), .err(err), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask

  task automatic m_end();
    m_active = 0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    m_csw = 1;
`else
    m_done = 1;
`endif
  endtask

  // model: image as a byte count against the requested word count
  always @(posedge clk) begin
    if (reset) begin
      m_init = 1; m_active = 0; m_csw = 0; m_done = 0; m_err = 0;
    end else if (!m_active && !m_csw && start) begin
      m_words = (len > 9'd256) ? 256 : int'(len);
      m_bytes = 0; m_addr = 0; m_xor = 0; m_done = 0; m_err = 0;
      if (m_words == 0) m_end();
      else m_active = 1;
    end else if (m_active && in_valid) begin
      m_word = {m_word[23:0], in_data};
      m_xor ^= in_data;
      m_bytes++;
      if (m_bytes % 4 == 0) begin
        exp_mem[m_addr % 256] = m_word;
        known[m_addr % 256] = 1;
        m_addr++;
        if (m_bytes == 4 * m_words) m_end();
      end
    end else if (m_csw && in_valid) begin
      m_csw = 0; m_done = 1; m_err = in_data != m_xor;
    end
  end

  always @(negedge clk) if (m_init) begin
    chk("in_ready", in_ready, m_active || m_csw);
    chk("busy", busy, m_active || m_csw);
    chk("done", done, m_done);
    chk("err", err, m_err);
    chk("cpu_hold", cpu_hold, !(m_done && !m_err));
    if (known[fetch_addr]) chk("fetch_instr", fetch_instr, exp_mem[fetch_addr]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    in_valid = 1; in_data = b; fetch_addr = 8'($urandom);
    step();
    in_valid = 0;
    if (gap) step();
  endtask

  task automatic go(input int l);
    len = 9'(l); start = 1;
    step();
    start = 0;
  endtask

  task automatic fin(input logic [7:0] c);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(c, 0);
`else
    in_data = c;
`endif
  endtask

  task automatic peek(input logic [7:0] a, input logic [31:0] e, input string n);
    fetch_addr = a;
    #1;
    chk(n, fetch_instr, e);
  endtask

  initial begin
    step(); step();
    reset = 0;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cpu_hold", cpu_hold, 1);
    step();
    go(2);
    for (int i = 0; i < 8; i++) send(img[i], 0);
    fin(8'h41);
    chk("t1_done", done, 1);
    chk("t1_cpu_hold", cpu_hold, 0);
    peek(8'd0, 32'hE2110000, "t1_mem0");
    peek(8'd1, 32'hE0805183, "t1_mem1");
    go(2);
    for (int i = 0; i < 7; i++) send(img[i], 1);
    chk("t2_done_early", done, 0);
    send(img[7], 0);
    fin(8'h41);
    chk("t2_done", done, 1);
    peek(8'd0, 32'hE2110000, "t2_mem0");
    peek(8'd1, 32'hE0805183, "t2_mem1");
    go(0);
    fin(8'h00);
    chk("len0_done", done, 1);
    chk("len0_err", err, 0);
    peek(8'd0, 32'hE2110000, "len0_mem0");
    go(3);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0); send(8'h55, 0);
    reset = 1;
    step();
    reset = 0;
    chk("rst_mid_in_ready", in_ready, 0);
    chk("rst_mid_cpu_hold", cpu_hold, 1);
    chk("rst_mid_busy", busy, 0);
    peek(8'd0, 32'h11223344, "rst_mid_mem0");
    peek(8'd1, 32'hE0805183, "rst_mid_mem1");
`ifdef IMEM_LOADER_CHECKSUM_EN
    go(1);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    send(8'h04, 0);
    chk("csum_ok_err", err, 0);
    chk("csum_ok_hold", cpu_hold, 0);
    go(1);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    send(8'h05, 0);
    chk("csum_bad_err", err, 1);
    chk("csum_bad_hold", cpu_hold, 1);
    chk("csum_bad_done", done, 1);
`endif
    go(300);
    for (int w = 0; w < 256; w++) begin
      logic [7:0] wb;
      wb = 8'(w);
      for (int k = 0; k < 4; k++) begin
        if (w == 3 && k == 1) begin start = 1; len = 9'd5; end
        send(k == 0 ? wb : k == 1 ? ~wb : k == 2 ? 8'hA5 : wb ^ 8'h3C, 0);
        start = 0;
      end
      if (w == 254) chk("big_not_done", done, 0);
    end
    fin(m_xor);
    chk("big_done", done, 1);
    peek(8'd0, 32'h00FFA53C, "big_mem0");
    peek(8'd255, 32'hFF00A5C3, "big_mem255");
    go(1);
    send(8'hDE, 0); send(8'hAD, 0); send(8'hBE, 0); send(8'hEF, 0);
    fin(8'h22);
    peek(8'd0, 32'hDEADBEEF, "wrap_mem0");
    peek(8'd1, 32'h01FEA53D, "wrap_mem1");
    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory writer for the pipelined core: accepts a byte stream over a valid/ready handshake and assembles 32-bit instruction words. Words are written sequentially from address 0 into an internal instruction RAM. The fetch stage reads the same RAM through an asynchronous read port indexed by the 8-bit PC. While a program is loading, the loader holds the core in reset via `cpu_hold`, and releases it once the image is complete.

## Interface
- `DEPTH`, 256, number of 32-bit instruction words; power of two.
- `ADDR_W`, 8, word-address width; equals log2(DEPTH) and matches PC width.
- `clk` in 1: single clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse that begins a load; sampled only in IDLE or DONE.
- `len` in ADDR_W+1: number of words to load, sampled with `start`; values above DEPTH saturate to DEPTH.
- `in_data` in 8: stream byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: loader accepts a byte this cycle.
- `fetch_addr` in ADDR_W: word address from the PC.
- `fetch_instr` out 32: combinational `mem[fetch_addr]`.
- `busy` out 1: a load is in progress.
- `done` out 1: the last load completed.
- `err` out 1: checksum mismatch on the last load (macro-dependent).
- `cpu_hold` out 1: drives the PC/pipeline reset; high in every state except DONE.

## Operation
- FSM states:
  - IDLE: after reset.
  - LOAD: accepting word bytes.
  - CSUM: macro only.
  - DONE: program resident, core released.
- Reset values: state=IDLE, `in_ready`=0, `busy`=0, `done`=0, `err`=0, `cpu_hold`=1, byte counter=0, word address=0, checksum=0. RAM contents are not cleared.
- IDLE/DONE with `start`=1:
  - Latch the effective length, clear the word address, byte counter, checksum and `err`.
  - Go to LOAD, or straight to the end state if length is 0.
- LOAD:
  - `in_ready`=1 and `busy`=1.
  - A byte transfers on any edge where `in_valid`&&`in_ready`.
  - Bytes are big-endian: byte 0 goes to [31:24] and byte 3 to [7:0].
  - On the 4th byte, write the assembled word to `mem[addr]` and increment addr. Addr wraps modulo DEPTH, which is only reachable at len=DEPTH on the final word.
  - After the last word's 4th byte, go to the end state.
- End state: CSUM when `IMEM_LOADER_CHECKSUM_EN` is defined, otherwise DONE.
- DONE: `done`=1, `cpu_hold`=0, `in_ready`=0. Bytes presented in this state are not consumed.
- `start` in LOAD or CSUM is ignored.
- `reset` mid-load returns to IDLE immediately. Words already written stay in RAM, and `cpu_hold` stays asserted.
- `fetch_instr` is always live. During LOAD it returns the current, partially updated contents; the core is held, so this is harmless.

## Timing
- Byte accept to RAM write: the word is written on the same edge as its 4th byte and is visible on `fetch_instr` in the following cycle.
- Last accepted byte to DONE: 1 edge without the macro. With the macro, the checksum byte's edge moves the FSM to DONE.
- `start` to `in_ready`=1: 1 cycle.
- `cpu_hold` deasserts in the first cycle of DONE, so the PC leaves reset the next edge and fetches address 0.
- `in_valid` may stay high continuously, giving one byte per cycle; gaps in `in_valid` stall without losing bytes.

## Configuration
- Macro: `IMEM_LOADER_CHECKSUM_EN`.
- Defined:
  - A running XOR of all image bytes is kept.
  - After the last word, CSUM accepts exactly one byte with `in_ready`=1.
  - If that byte ≠ the running XOR, set `err`=1. Enter DONE either way.
  - With `err`=1, `cpu_hold` stays 1 in DONE, so a corrupt image is never executed.
  - len=0 goes to CSUM, which expects byte 0x00.
- Undefined: no checksum register, no CSUM state, and `err` is tied to 0.

## Structure
- Shared package holds:
  - the FSM state encoding (IDLE=0, LOAD=1, CSUM=2, DONE=3);
  - the default DEPTH/ADDR_W;
  - an instruction word width constant of 32 shared with the control unit.
- One natural sub-module: `imem_ram`, a DEPTH×32 RAM with one synchronous write port and one asynchronous read port. It can be reused wherever the fetch stage needs plain instruction storage.
- The FSM, byte assembler and checksum stay in `imem_loader`.

## Test plan
- Reset, then `start`, len=2, bytes E2 11 00 00 E0 80 51 83 back-to-back:
  - mem[0]=E2110000 and mem[1]=E0805183.
  - `done`=1 and `cpu_hold`=0 one cycle after the 8th byte.
- Same image with `in_valid` toggled every other cycle: identical RAM contents; `done` arrives 8 accepted bytes later.
- `start` with len=0: DONE on the next cycle without the macro; RAM untouched.
- Assert `reset` after 5 bytes of a len=3 load:
  - IDLE, `cpu_hold`=1, `in_ready`=0.
  - mem[0] keeps the word written before reset.
- With `IMEM_LOADER_CHECKSUM_EN`, len=1, bytes 01 02 03 04:
  - checksum byte 04 → `err`=0 and `cpu_hold`=0;
  - checksum byte 05 → `err`=1 and `cpu_hold`=1.
- `start` pulsed mid-LOAD and len=300: the pulse is ignored, and the load ends after 256 words with addr wrapped to 0.
